// File: rtl/rsp_s2_dma_ahbic_pkg.sv
// Shared encodings for the rsp_s2_dma_ahbic output-stage arbiter: AHB HTRANS/HBURST codes, FSM states, burst reload.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package rsp_s2_dma_ahbic_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_BURST = 2'd2,
        ST_LOCK  = 2'd3
    } arb_state_e;

    // Beats remaining after the NONSEQ beat of a fixed-length burst.
    // SINGLE and undefined-length INCR never pin the grant through the counter.
    function automatic logic [3:0] burst_len(input logic [2:0] hburst);
        logic [3:0] len;
        case (hburst)
            HBURST_WRAP4,  HBURST_INCR4:  len = 4'd3;
            HBURST_WRAP8,  HBURST_INCR8:  len = 4'd7;
            HBURST_WRAP16, HBURST_INCR16: len = 4'd15;
            default:                      len = 4'd0;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/rsp_s2_dma_ahbic_rr_pick.sv
// Rotating-priority picker: first asserted request strictly after ptr_i, wrapping modulo NUM_PORTS.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rsp_s2_dma_ahbic_rr_pick
    import rsp_s2_dma_ahbic_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [PORT_W-1:0]    ptr_i,
    output logic [PORT_W-1:0]    win_o,
    output logic                 any_o
);

    logic [PORT_W-1:0] idx;

    // Walk NUM_PORTS positions starting one past the last winner; first hit wins.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        idx   = '0;
        if ({1'b0, ptr_i} >= (PORT_W+1)'(NUM_PORTS)) begin
            // A pointer outside the port range cannot be produced by the top level.
            win_o = 'x;
            any_o = |req_i;
        end else begin
            for (int i = 1; i <= NUM_PORTS; i++) begin
                idx = PORT_W'((int'(ptr_i) + i) % NUM_PORTS);
                if (!any_o && req_i[idx]) begin
                    any_o = 1'b1;
                    win_o = idx;
                end
            end
        end
    end

endmodule

// File: rtl/rsp_s2_dma_ahbic_rr_arb.sv
// Round-robin arbiter choosing which bus-switch input owns the shared slave address phase.
// Latency: request seen with HREADYM=1 and no hold -> addr_in_port/no_port registered next cycle.
// Backpressure: HREADYM=0 freezes every register; fixed bursts, BUSY and locked sequences hold the grant.
module rsp_s2_dma_ahbic_rr_arb
    import rsp_s2_dma_ahbic_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [NUM_PORTS-1:0] req_port,
    input  logic                 HREADYM,
    input  logic                 HSELM,
    input  logic [1:0]           HTRANSM,
    input  logic [2:0]           HBURSTM,
    input  logic                 HMASTLOCKM,
    output logic [PORT_W-1:0]    addr_in_port,
    output logic                 no_port
);

    arb_state_e        state_q, state_d;
    logic [3:0]        burst_cnt_q, burst_cnt_d;
    logic [PORT_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PORT_W-1:0] addr_q, addr_d;
    logic              no_port_q, no_port_d;

    logic [PORT_W-1:0] pick_win;
    logic              pick_any;
    logic              cnt_live;
    logic              busy_hold;
    logic              rearb;

    rsp_s2_dma_ahbic_rr_pick #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) u_pick (
        .req_i (req_port),
        .ptr_i (rr_ptr_q),
        .win_o (pick_win),
        .any_o (pick_any)
    );

    // Burst beat counter: value it takes this cycle if HREADYM allows the update.
    always_comb begin
        burst_cnt_d = '0;
        if (HSELM) begin
            case (HTRANSM)
                HTRANS_NONSEQ: burst_cnt_d = burst_len(HBURSTM);
                HTRANS_SEQ:    burst_cnt_d = (burst_cnt_q != 4'd0) ? burst_cnt_q - 4'd1 : 4'd0;
                HTRANS_BUSY:   burst_cnt_d = burst_cnt_q;
                default:       burst_cnt_d = '0;   // IDLE terminates the burst early
            endcase
        end
    end

    assign cnt_live  = (burst_cnt_d != 4'd0);
    assign busy_hold = HSELM && (HTRANSM == HTRANS_BUSY);

    // Grant FSM: decide whether the current owner keeps the bus or the picker runs.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        no_port_d = no_port_q;
        rr_ptr_d  = rr_ptr_q;
        rearb     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                rearb = 1'b1;
            end
            ST_GRANT, ST_BURST, ST_LOCK: begin
                if (HMASTLOCKM) begin
                    state_d = ST_LOCK;
                end else if (cnt_live) begin
                    state_d = ST_BURST;
                end else if (busy_hold) begin
                    // A BUSY beat keeps the owner; leaving a lock falls back to plain grant.
                    state_d = (state_q == ST_LOCK) ? ST_GRANT : state_q;
                end else begin
                    rearb = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                no_port_d = 1'b1;
            end
        endcase

        // Re-arbitration: a winner gets the bus; with nobody asking the mux idles
        // and both the last index and the pointer are left where they were.
        if (rearb) begin
            if (pick_any) begin
                state_d   = ST_GRANT;
                addr_d    = pick_win;
                rr_ptr_d  = pick_win;
                no_port_d = 1'b0;
            end else begin
                state_d   = ST_IDLE;
                no_port_d = 1'b1;
            end
        end
    end

    // State and output registers: reset wins over everything, HREADYM=0 freezes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            burst_cnt_q <= '0;
            rr_ptr_q    <= PORT_W'(NUM_PORTS - 1);
            addr_q      <= '0;
            no_port_q   <= 1'b1;
        end else if (HREADYM) begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            addr_q      <= addr_d;
            no_port_q   <= no_port_d;
        end
    end

    assign addr_in_port = addr_q;
    assign no_port      = no_port_q;

endmodule

// File: tb/tb_rsp_s2_dma_ahbic_rr_arb.sv
// Directed bench for the round-robin output-stage arbiter.
// Latency: one step() = one HCLK edge; outputs sampled 1 time unit after the edge.
// Backpressure: exercised through HREADYM stalls mid-burst and during reset.
module tb_rsp_s2_dma_ahbic_rr_arb;
    import rsp_s2_dma_ahbic_pkg::*;

    localparam int NUM_PORTS = 4;
    localparam int PORT_W    = 2;

    logic                 HCLK;
    logic                 HRESET;
    logic [NUM_PORTS-1:0] req_port;
    logic                 HREADYM;
    logic                 HSELM;
    logic [1:0]           HTRANSM;
    logic [2:0]           HBURSTM;
    logic                 HMASTLOCKM;
    logic [PORT_W-1:0]    addr_in_port;
    logic                 no_port;

    int n_vec;
    int n_err;

    rsp_s2_dma_ahbic_rr_arb #(
        .NUM_PORTS (NUM_PORTS),
        .PORT_W    (PORT_W)
    ) dut (
        .HCLK         (HCLK),
        .HRESET       (HRESET),
        .req_port     (req_port),
        .HREADYM      (HREADYM),
        .HSELM        (HSELM),
        .HTRANSM      (HTRANSM),
        .HBURSTM      (HBURSTM),
        .HMASTLOCKM   (HMASTLOCKM),
        .addr_in_port (addr_in_port),
        .no_port      (no_port)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive(input logic sel, input logic [1:0] trans, input logic [2:0] burst);
        HSELM   = sel;
        HTRANSM = trans;
        HBURSTM = burst;
    endtask

    initial begin
        logic [1:0] fair_exp [5];
        n_vec = 0;
        n_err = 0;
        fair_exp[0] = 2'd1; fair_exp[1] = 2'd2; fair_exp[2] = 2'd3;
        fair_exp[3] = 2'd0; fair_exp[4] = 2'd1;

        HRESET     = 1'b1;
        req_port   = 4'b1111;
        HREADYM    = 1'b1;
        HMASTLOCKM = 1'b0;
        drive(1'b0, HTRANS_IDLE, HBURST_SINGLE);

        // 1: reset held 3 cycles with all ports requesting
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_port", 32'(no_port), 32'd1);
            chk("rst_addr", 32'(addr_in_port), 32'd0);
        end
        HRESET = 1'b0;
        step();
        chk("first_grant", 32'(addr_in_port), 32'd0);
        chk("first_no_port", 32'(no_port), 32'd0);

        // 2: fairness, SINGLE NONSEQ every cycle
        drive(1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("fair_%0d", i), 32'(addr_in_port), 32'(fair_exp[i]));
        end
        // now owner=1, ptr=1; drop everything -> IDLE, index kept
        req_port = 4'b0000;
        drive(1'b0, HTRANS_IDLE, HBURST_SINGLE);
        step();
        chk("to_idle_no_port", 32'(no_port), 32'd1);
        chk("to_idle_addr", 32'(addr_in_port), 32'd1);

        // 3a: port1 INCR4 while port2 waits (ptr=1 so port2 would otherwise win first)
        req_port = 4'b0010;
        step();
        chk("b4_grant", 32'(addr_in_port), 32'd1);
        req_port = 4'b0110;
        drive(1'b1, HTRANS_NONSEQ, HBURST_INCR4);
        step();
        chk("b4_beat1", 32'(addr_in_port), 32'd1);
        chk("b4_cnt", 32'(dut.burst_cnt_q), 32'd3);
        drive(1'b1, HTRANS_SEQ, HBURST_INCR4);
        step();
        chk("b4_beat2", 32'(addr_in_port), 32'd1);
        step();
        chk("b4_beat3", 32'(addr_in_port), 32'd1);
        step();
        chk("b4_handover", 32'(addr_in_port), 32'd2);

        // 3b: port2 INCR4 with a 2-cycle HREADYM stall, ports 2 and 3 requesting
        req_port = 4'b1100;
        drive(1'b1, HTRANS_NONSEQ, HBURST_INCR4);
        step();
        chk("stl_beat1", 32'(addr_in_port), 32'd2);
        drive(1'b1, HTRANS_SEQ, HBURST_INCR4);
        step();
        chk("stl_beat2", 32'(addr_in_port), 32'd2);
        HREADYM = 1'b0;
        step();
        step();
        chk("stl_frozen_addr", 32'(addr_in_port), 32'd2);
        chk("stl_frozen_cnt", 32'(dut.burst_cnt_q), 32'd2);
        HREADYM = 1'b1;
        step();
        chk("stl_beat3", 32'(addr_in_port), 32'd2);
        step();
        chk("stl_handover", 32'(addr_in_port), 32'd3);

        req_port = 4'b0000;
        drive(1'b0, HTRANS_IDLE, HBURST_SINGLE);
        step();
        chk("idle2_no_port", 32'(no_port), 32'd1);

        // 4: port0 WRAP8 terminated by IDLE after beat 3, port3 waiting
        req_port = 4'b0001;
        step();
        chk("w8_grant", 32'(addr_in_port), 32'd0);
        req_port = 4'b1001;
        drive(1'b1, HTRANS_NONSEQ, HBURST_WRAP8);
        step();
        chk("w8_cnt", 32'(dut.burst_cnt_q), 32'd7);
        drive(1'b1, HTRANS_SEQ, HBURST_WRAP8);
        step();
        step();
        chk("w8_beat3", 32'(addr_in_port), 32'd0);
        drive(1'b1, HTRANS_IDLE, HBURST_WRAP8);
        step();
        chk("w8_early_cnt", 32'(dut.burst_cnt_q), 32'd0);
        chk("w8_handover", 32'(addr_in_port), 32'd3);

        // 5: port2 locked for 3 transfers, drops its request mid-sequence
        req_port = 4'b0100;
        drive(1'b0, HTRANS_IDLE, HBURST_SINGLE);
        step();
        chk("lk_grant", 32'(addr_in_port), 32'd2);
        HMASTLOCKM = 1'b1;
        drive(1'b1, HTRANS_NONSEQ, HBURST_SINGLE);
        for (int i = 0; i < 3; i++) begin
            req_port = (i == 0) ? 4'b0101 : 4'b0001;
            step();
            chk($sformatf("lk_addr_%0d", i), 32'(addr_in_port), 32'd2);
            chk($sformatf("lk_no_port_%0d", i), 32'(no_port), 32'd0);
        end
        HMASTLOCKM = 1'b0;
        drive(1'b1, HTRANS_IDLE, HBURST_SINGLE);
        step();
        chk("lk_release", 32'(addr_in_port), 32'd0);

        // 6: reset during beat 2 of port1 INCR16, with HREADYM low as well
        req_port = 4'b0010;
        drive(1'b0, HTRANS_IDLE, HBURST_SINGLE);
        step();
        chk("r16_grant", 32'(addr_in_port), 32'd1);
        drive(1'b1, HTRANS_NONSEQ, HBURST_INCR16);
        step();
        chk("r16_cnt", 32'(dut.burst_cnt_q), 32'd15);
        chk("r16_state", 32'(dut.state_q), 32'(ST_BURST));
        drive(1'b1, HTRANS_SEQ, HBURST_INCR16);
        HRESET  = 1'b1;
        HREADYM = 1'b0;
        step();
        chk("r16_no_port", 32'(no_port), 32'd1);
        chk("r16_addr", 32'(addr_in_port), 32'd0);
        chk("r16_cnt_clr", 32'(dut.burst_cnt_q), 32'd0);
        chk("r16_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        HRESET   = 1'b0;
        HREADYM  = 1'b1;
        req_port = 4'b1111;
        drive(1'b0, HTRANS_IDLE, HBURST_SINGLE);
        step();
        chk("r16_regrant", 32'(addr_in_port), 32'd0);
        chk("r16_regrant_np", 32'(no_port), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
